// File: rtl/prbs31_data_generator.sv
// ============================================================================
// Module   : prbs31_data_generator
// Purpose  : PRBS31 (x^31 + x^28 + 1) 32-bit word source with single-shot and
//            periodic error injection plus a saturating injected-error count.
//            Define PRBS31_GEN_BURST_EN to replace inject_bit with inject_mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_data_generator #(
  parameter logic [30:0] SEED     = 31'h7FFF_FFFF,
  parameter int          PERIOD_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [30:0]         seed,
  input  logic                inject_pulse,
`ifdef PRBS31_GEN_BURST_EN
  input  logic [31:0]         inject_mask,
`else
  input  logic [4:0]          inject_bit,
`endif
  input  logic [PERIOD_W-1:0] inject_period,
  input  logic                count_clear,
  output logic [31:0]         data_out,
  output logic                data_valid,
  output logic [15:0]         inject_error_count,
  output logic                seed_err
);

  localparam logic [0:0]          c_st_idle    = 1'b0;
  localparam logic [0:0]          c_st_run     = 1'b1;
  localparam logic [PERIOD_W-1:0] c_period_one = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [0:0]          r_state;
  logic [30:0]         r_history;
  logic [31:0]         r_data_out;
  logic                r_data_valid;
  logic [15:0]         r_count;
  logic                r_armed;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [PERIOD_W-1:0] r_period_prev;
  logic                r_seed_err;

  logic [0:0]          w_state_next;
  logic                w_emit;
  logic [62:0]         w_stream;
  logic [31:0]         w_word;
  logic                w_period_changed;
  logic [PERIOD_W-1:0] w_cnt_eff;
  logic                w_period_hit;
  logic [PERIOD_W-1:0] w_period_cnt_next;
  logic                w_inject;
  logic [31:0]         w_mask;
  logic [5:0]          w_inc;
  logic [5:0]          w_inc_eff;
  logic [16:0]         w_count_sum;
  logic [15:0]         w_count_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (enable)  w_state_next = c_st_run;
      c_st_run:  if (!enable) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // A seed load steals the cycle: no word is produced while history reloads.
  assign w_emit = (w_state_next == c_st_run) && !seed_load;

  // Bits [30:0] are history s[n-31..n-1]; bits [62:31] are the new word.
  always_comb begin
    w_stream       = '0;
    w_stream[30:0] = r_history;
    for (int i = 0; i < 32; i++) begin
      w_stream[31+i] = w_stream[i] ^ w_stream[i+3];
    end
  end

  assign w_word = w_stream[62:31];

  // A period change restarts the count on the very cycle it is seen.
  assign w_period_changed = (inject_period != r_period_prev);
  assign w_cnt_eff        = w_period_changed ? '0 : r_period_cnt;
  assign w_period_hit     = w_emit && (inject_period != '0) &&
                            (w_cnt_eff == (inject_period - c_period_one));

  always_comb begin
    w_period_cnt_next = w_cnt_eff;
    if (inject_period == '0) begin
      w_period_cnt_next = '0;
    end else if (w_emit) begin
      w_period_cnt_next = w_period_hit ? '0 : (w_cnt_eff + c_period_one);
    end
  end

`ifdef PRBS31_GEN_BURST_EN
  assign w_mask = inject_mask;
  assign w_inc  = 6'($countones(inject_mask));
`else
  assign w_mask = 32'd1 << inject_bit;
  assign w_inc  = 6'd1;
`endif

  // Pulse and periodic hit on the same word collapse into one injection.
  assign w_inject     = w_emit && (r_armed || inject_pulse || w_period_hit);
  assign w_inc_eff    = w_inject ? w_inc : 6'd0;
  assign w_count_sum  = {1'b0, r_count} + {11'd0, w_inc_eff};
  assign w_count_next = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_history     <= SEED;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_count       <= '0;
      r_armed       <= 1'b0;
      r_period_cnt  <= '0;
      r_period_prev <= '0;
      r_seed_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_data_valid  <= w_emit;
      r_period_prev <= inject_period;
      r_period_cnt  <= w_period_cnt_next;
      if (seed_load) begin
        r_history <= (seed == '0) ? SEED : seed;
        if (seed == '0) r_seed_err <= 1'b1;
      end else if (w_emit) begin
        r_history <= w_stream[62:32];
      end
      // Corruption touches only the output register, never the history.
      if (w_emit) begin
        r_data_out <= w_word ^ (w_inject ? w_mask : 32'd0);
        r_armed    <= 1'b0;
      end else begin
        r_armed    <= r_armed | inject_pulse;
      end
      r_count <= count_clear ? 16'd0 : w_count_next;
    end
  end

  assign data_out           = r_data_out;
  assign data_valid         = r_data_valid;
  assign inject_error_count = r_count;
  assign seed_err           = r_seed_err;

endmodule

`default_nettype wire

// File: tb/tb_prbs31_data_generator.sv
// Self-checking bench for prbs31_data_generator: a bit-queue reference model of
// the stream law plus a self-synchronising checker model over the DUT output.
`default_nettype none

module tb_prbs31_data_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [30:0] seed = '0;
  logic        inject_pulse = 1'b0;
  logic [4:0]  inject_bit = '0;
  logic [31:0] inject_period = '0;
  logic        count_clear = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic [15:0] inject_error_count;
  logic        seed_err;

  always #5 clock = ~clock;

  prbs31_data_generator #(.SEED(31'h7FFF_FFFF), .PERIOD_W(32)) u_dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .seed_load          (seed_load),
    .seed               (seed),
    .inject_pulse       (inject_pulse),
`ifdef PRBS31_GEN_BURST_EN
    .inject_mask        (32'd1 << inject_bit),
`else
    .inject_bit         (inject_bit),
`endif
    .inject_period      (inject_period),
    .count_clear        (count_clear),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .inject_error_count (inject_error_count),
    .seed_err           (seed_err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: stream history kept as a plain bit queue, oldest first.
  bit          m_hist[$];
  logic [31:0] m_out, m_clean;
  logic        m_valid, m_armed, m_seed_err;
  logic [15:0] m_count;
  int          m_pidx;
  logic [31:0] m_prev_period;

  task automatic m_load(input logic [30:0] s);
    m_hist.delete();
    for (int i = 0; i < 31; i++) m_hist.push_back(s[i]);
  endtask

  task automatic m_gen(output logic [31:0] w);
    bit b;
    for (int i = 0; i < 32; i++) begin
      b = m_hist[0] ^ m_hist[3];
      m_hist.push_back(b);
      void'(m_hist.pop_front());
      w[i] = b;
    end
  endtask

  task automatic m_reset();
    m_load(31'h7FFF_FFFF);
    m_out = '0; m_clean = '0; m_valid = 1'b0; m_armed = 1'b0;
    m_seed_err = 1'b0; m_count = '0; m_pidx = 0; m_prev_period = '0;
  endtask

  // Checker model: counts bits violating s[k] = s[k-31] ^ s[k-28] in the received stream.
  bit c_q[$];
  int chk_err = 0;
  bit chk_on  = 1'b0;

  task automatic chk_feed(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      if (c_q.size() == 31) begin
        if (w[i] != (c_q[0] ^ c_q[3])) chk_err++;
        void'(c_q.pop_front());
      end
      c_q.push_back(w[i]);
    end
  endtask

  // One clock: update the model from the driven inputs, clock, then compare.
  task automatic cyc();
    logic [31:0] w;
    bit          hit;
    if (reset) begin
      m_reset();
    end else begin
      if (inject_period != m_prev_period) begin
        m_pidx = 0;
        m_prev_period = inject_period;
      end
      m_valid = 1'b0;
      if (seed_load) begin
        if (seed == '0) begin
          m_load(31'h7FFF_FFFF);
          m_seed_err = 1'b1;
        end else begin
          m_load(seed);
        end
        m_armed = m_armed | inject_pulse;
      end else if (enable) begin
        m_gen(w);
        m_clean = w;
        hit = (inject_period != 0) &&
              ((longint'(m_pidx) % longint'(inject_period)) == longint'(inject_period) - 1);
        if (m_armed || inject_pulse || hit) begin
          w[inject_bit] = ~w[inject_bit];
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
        m_armed = 1'b0;
        m_pidx++;
        m_out   = w;
        m_valid = 1'b1;
      end else begin
        m_armed = m_armed | inject_pulse;
      end
      if (count_clear) m_count = '0;
    end
    @(posedge clock);
    @(negedge clock);
    check_value("data_valid", data_valid, m_valid);
    check_value("data_out", data_out, m_out);
    check_value("count", inject_error_count, m_count);
    check_value("seed_err", seed_err, m_seed_err);
    if (chk_on && data_valid) chk_feed(data_out);
    seed_load    = 1'b0;
    inject_pulse = 1'b0;
    count_clear  = 1'b0;
  endtask

  int e0;
  int inj_words;

  initial begin
    m_reset();
    @(negedge clock);
    reset = 1'b1;
    cyc();
    cyc();
    check_value("rst_data_out", data_out, 32'h0);
    check_value("rst_valid", data_valid, 32'h0);
    check_value("rst_count", inject_error_count, 32'h0);
    reset = 1'b0;

    // Known-answer words from the all-ones seed.
    seed = 31'h7FFF_FFFF; seed_load = 1'b1;
    cyc();
    check_value("load_valid", data_valid, 32'h0);
    enable = 1'b1;
    cyc();
    check_value("first_word", data_out, 32'h7000_0000);
    check_value("first_valid", data_valid, 32'h1);
    cyc();
    check_value("second_word", data_out, 32'h3F00_0000);

    // Long clean run with a 10-cycle hold in the middle.
    c_q.delete(); chk_err = 0; chk_on = 1'b1;
    for (int i = 0; i < 3010; i++) begin
      enable = !(i >= 1500 && i < 1510);
      cyc();
    end
    enable = 1'b1;
    check_value("chk_err_clean", chk_err, 32'd0);

    // Single injection at bit 5: one flipped bit, three checker errors.
    e0 = chk_err;
    inject_bit = 5'd5; inject_pulse = 1'b1;
    cyc();
    check_value("pulse_flip", data_out ^ m_clean, 32'h0000_0020);
    check_value("pulse_count", inject_error_count, 32'd1);
    for (int i = 0; i < 10; i++) cyc();
    check_value("chk_err_delta", chk_err - e0, 32'd3);
    chk_on = 1'b0;

    // Periodic injection every 100 words, plus a merged pulse on index 199.
    count_clear = 1'b1;
    cyc();
    inject_period = 32'd100;
    inj_words = 0;
    for (int i = 0; i < 1000; i++) begin
      inject_pulse = (m_pidx == 199);
      cyc();
      if (data_out != m_clean) inj_words++;
    end
    check_value("period_words", inj_words, 32'd10);
    check_value("period_count", inject_error_count, 32'd10);
    inject_period = '0;

    // Randomized mix of enable, seed loads, pulses, clears and periods.
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 7) != 0);
      seed_load    = ($urandom_range(0, 63) == 0);
      seed         = 31'($urandom);
      inject_pulse = ($urandom_range(0, 15) == 0);
      inject_bit   = 5'($urandom_range(0, 31));
      count_clear  = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 199) == 0) inject_period = 32'($urandom_range(0, 20));
      cyc();
    end
    inject_period = '0;
    enable = 1'b0;
    cyc();

    // Zero seed falls back to SEED and raises the sticky flag.
    seed = '0; seed_load = 1'b1;
    cyc();
    check_value("seed_err_set", seed_err, 32'h1);
    enable = 1'b1;
    cyc();
    check_value("zero_seed_word", data_out, 32'h7000_0000);

    // Saturation: inject on every word well past 16'hFFFF.
    count_clear = 1'b1;
    cyc();
    inject_period = 32'd1;
    for (int i = 0; i < 65540; i++) cyc();
    check_value("count_sat", inject_error_count, 32'h0000_FFFF);
    count_clear = 1'b1;
    cyc();
    check_value("clear_wins", inject_error_count, 32'h0);
    inject_period = '0;
    cyc();

    // Reset while running with a pulse armed during a seed load.
    seed = 31'h1234_5678; seed_load = 1'b1; inject_pulse = 1'b1; inject_bit = 5'd9;
    cyc();
    reset = 1'b1;
    cyc();
    check_value("mid_rst_data", data_out, 32'h0);
    check_value("mid_rst_valid", data_valid, 32'h0);
    check_value("mid_rst_count", inject_error_count, 32'h0);
    check_value("mid_rst_seed_err", seed_err, 32'h0);
    reset = 1'b0;
    cyc();
    check_value("post_rst_word", data_out, 32'h7000_0000);
    check_value("post_rst_count", inject_error_count, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
